// File: rtl/int_hit_collect.sv
// int_hit_collect: reduces the per-triangle intersection stream of each ray
// to a single closest-hit (or miss) record. Finished records are queued in a
// small FIFO and handed to the return path over valid/ready. A registered
// stall throttles the ray issuer before the FIFO runs out of room.
//
// Build option: INT_COLLECT_ANYHIT_EN selects any-hit reduction (the first
// valid hit of a stream is kept) instead of closest-hit.
//
// state | meaning
// IDLE  | no ray open, waiting for a first result
// ACCUM | ray open, best candidate held in best_q
module int_hit_collect #(
    parameter int unsigned RAYID_W = 8,
    parameter int unsigned TRIID_W = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned SKID    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               int_valid_in,
    input  logic               int_first_in,
    input  logic               int_last_in,
    input  logic [RAYID_W-1:0] int_rayID_in,
    input  logic               int_hit_in,
    input  logic [31:0]        int_t_in,
    input  logic [31:0]        int_u_in,
    input  logic [31:0]        int_v_in,
    input  logic [TRIID_W-1:0] int_triID_in,
    output logic               int_stall_out,
    output logic               res_valid_out,
    input  logic               res_ready_in,
    output logic [RAYID_W-1:0] res_rayID_out,
    output logic               res_hit_out,
    output logic [31:0]        res_t_out,
    output logic [31:0]        res_u_out,
    output logic [31:0]        res_v_out,
    output logic [TRIID_W-1:0] res_triID_out,
    output logic               err_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [RAYID_W-1:0] ray_id;
        logic               hit;
        logic [31:0]        t;
        logic [31:0]        u;
        logic [31:0]        v;
        logic [TRIID_W-1:0] tri_id;
    } rec_t;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t state_q;
    rec_t   best_q;
    rec_t   cand;
    rec_t   merged;
    rec_t   push_rec;
    logic   cand_hit;
    logic   take_cand;
    logic   push;
    logic   proto_err;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             do_push;
    logic             overflow;

    // Normalise the incoming result: negative t counts as a miss, and a miss
    // carries no geometry data.
    always_comb begin
        cand_hit    = int_hit_in & ~int_t_in[31];
        cand.ray_id = int_rayID_in;
        cand.hit    = cand_hit;
        cand.t      = cand_hit ? int_t_in     : '0;
        cand.u      = cand_hit ? int_u_in     : '0;
        cand.v      = cand_hit ? int_v_in     : '0;
        cand.tri_id = cand_hit ? int_triID_in : '0;
    end

    // Merge decision; the record keeps the ray ID of the stream that opened it.
    // Ties on t keep the earlier result (strict less-than).
    always_comb begin
`ifdef INT_COLLECT_ANYHIT_EN
        take_cand = cand_hit & ~best_q.hit;
`else
        take_cand = cand_hit & (~best_q.hit | (cand.t[30:0] < best_q.t[30:0]));
`endif
        merged        = take_cand ? cand : best_q;
        merged.ray_id = best_q.ray_id;
    end

    // Decide what, if anything, is pushed this cycle and flag protocol errors.
    always_comb begin
        push      = 1'b0;
        push_rec  = cand;
        proto_err = 1'b0;
        if (int_valid_in) begin
            case (state_q)
                IDLE: begin
                    if (!int_first_in)
                        proto_err = 1'b1;
                    else if (int_last_in)
                        push = 1'b1;
                end
                ACCUM: begin
                    if (int_first_in) begin
                        proto_err = 1'b1;
                        push      = int_last_in;
                    end else begin
                        proto_err = (int_rayID_in != best_q.ray_id);
                        push      = int_last_in;
                        push_rec  = merged;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ray-stream FSM and best-record register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            best_q  <= '0;
        end else if (int_valid_in) begin
            case (state_q)
                IDLE: begin
                    if (int_first_in && !int_last_in) begin
                        best_q  <= cand;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (int_first_in) begin
                        best_q <= cand;
                        if (int_last_in)
                            state_q <= IDLE;
                    end else begin
                        best_q <= merged;
                        if (int_last_in)
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = (count != '0) & res_ready_in;
    assign do_push  = push & (~full | pop);
    assign overflow = push & full & ~pop;

    // Result FIFO; contents are cleared on reset so the head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_rec;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(pop);
        end
    end

    // Registered stall from the current occupancy, plus sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_stall_out <= 1'b0;
            err_out       <= 1'b0;
        end else begin
            int_stall_out <= (count >= CNT_W'(DEPTH - SKID));
            err_out       <= err_out | proto_err | overflow;
        end
    end

    assign res_valid_out = (count != '0);
    assign res_rayID_out = mem[rd_ptr].ray_id;
    assign res_hit_out   = mem[rd_ptr].hit;
    assign res_t_out     = mem[rd_ptr].t;
    assign res_u_out     = mem[rd_ptr].u;
    assign res_v_out     = mem[rd_ptr].v;
    assign res_triID_out = mem[rd_ptr].tri_id;

endmodule

// File: tb/tb_int_hit_collect.sv
// Directed bench for int_hit_collect with a scoreboard: stimulus queues the
// expected records, a negedge monitor compares each record as it transfers.
module tb_int_hit_collect;

    typedef struct packed {
        logic [7:0]  ray_id;
        logic        hit;
        logic [31:0] t;
        logic [31:0] u;
        logic [31:0] v;
        logic [15:0] tri_id;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_valid_in, int_first_in, int_last_in, int_hit_in;
    logic [7:0]  int_rayID_in;
    logic [31:0] int_t_in, int_u_in, int_v_in;
    logic [15:0] int_triID_in;
    logic        int_stall_out, res_valid_out, res_ready_in, res_hit_out, err_out;
    logic [7:0]  res_rayID_out;
    logic [31:0] res_t_out, res_u_out, res_v_out;
    logic [15:0] res_triID_out;

    int   vectors = 0;
    int   errors  = 0;
    rec_t exp_q[$];

    int_hit_collect #(.RAYID_W(8), .TRIID_W(16), .DEPTH(4), .SKID(2)) dut (
        .clk(clk), .rst(rst),
        .int_valid_in(int_valid_in), .int_first_in(int_first_in),
        .int_last_in(int_last_in), .int_rayID_in(int_rayID_in),
        .int_hit_in(int_hit_in), .int_t_in(int_t_in), .int_u_in(int_u_in),
        .int_v_in(int_v_in), .int_triID_in(int_triID_in),
        .int_stall_out(int_stall_out), .res_valid_out(res_valid_out),
        .res_ready_in(res_ready_in), .res_rayID_out(res_rayID_out),
        .res_hit_out(res_hit_out), .res_t_out(res_t_out), .res_u_out(res_u_out),
        .res_v_out(res_v_out), .res_triID_out(res_triID_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] u_of(input logic [15:0] tri_id);
        return {16'h1000, tri_id};
    endfunction

    function automatic logic [31:0] v_of(input logic [15:0] tri_id);
        return {16'h2000, tri_id};
    endfunction

    function automatic rec_t hit_rec(input logic [7:0] ray, input logic [31:0] t,
                                     input logic [15:0] tri_id);
        return '{ray_id: ray, hit: 1'b1, t: t, u: u_of(tri_id), v: v_of(tri_id), tri_id: tri_id};
    endfunction

    function automatic rec_t miss_rec(input logic [7:0] ray);
        return '{ray_id: ray, hit: 1'b0, t: 32'h0, u: 32'h0, v: 32'h0, tri_id: 16'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that samples it.
    task automatic drive(input logic f, input logic l, input logic [7:0] ray,
                         input logic h, input logic [31:0] t, input logic [15:0] tri_id);
        int_valid_in = 1'b1;
        int_first_in = f;
        int_last_in  = l;
        int_rayID_in = ray;
        int_hit_in   = h;
        int_t_in     = t;
        int_u_in     = u_of(tri_id);
        int_v_in     = v_of(tri_id);
        int_triID_in = tri_id;
        @(posedge clk); #1;
        int_valid_in = 1'b0;
        int_first_in = 1'b0;
        int_last_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        int budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: compare each record while it is being accepted.
    always @(negedge clk) begin
        if (!rst && res_valid_out && res_ready_in) begin
            rec_t act, exp;
            act = '{ray_id: res_rayID_out, hit: res_hit_out, t: res_t_out,
                    u: res_u_out, v: res_v_out, tri_id: res_triID_out};
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record: got ray=%h hit=%b t=%h tri=%h expected none",
                         act.ray_id, act.hit, act.t, act.tri_id);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL record: got ray=%h hit=%b t=%h u=%h v=%h tri=%h expected ray=%h hit=%b t=%h u=%h v=%h tri=%h",
                             act.ray_id, act.hit, act.t, act.u, act.v, act.tri_id,
                             exp.ray_id, exp.hit, exp.t, exp.u, exp.v, exp.tri_id);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        int_valid_in = 0; int_first_in = 0; int_last_in = 0; int_hit_in = 0;
        int_rayID_in = 0; int_t_in = 0; int_u_in = 0; int_v_in = 0; int_triID_in = 0;
        res_ready_in = 1'b1;
        idle(3);
        rst = 1'b0;
        check("reset_valid", res_valid_out, 0);
        check("reset_stall", int_stall_out, 0);
        check("reset_err", err_out, 0);
        check("reset_t", res_t_out, 0);
        check("reset_tri", res_triID_out, 0);

        // Ray 5: miss, hit 4.0 tri 7, hit 2.5 tri 9 (last)
`ifdef INT_COLLECT_ANYHIT_EN
        exp_q.push_back(hit_rec(8'd5, 32'h40800000, 16'd7));
`else
        exp_q.push_back(hit_rec(8'd5, 32'h40200000, 16'd9));
`endif
        drive(1, 0, 8'd5, 0, 32'h3F800000, 16'd3);
        drive(0, 0, 8'd5, 1, 32'h40800000, 16'd7);
        check("valid_before_last", res_valid_out, 0);
        drive(0, 1, 8'd5, 1, 32'h40200000, 16'd9);
        check("valid_after_last", res_valid_out, 1);
        idle(1);

        // Ray 3: single result, hit with negative t -> miss record
        exp_q.push_back(miss_rec(8'd3));
        drive(1, 1, 8'd3, 1, 32'hBF800000, 16'd6);
        idle(1);

        // Ray 6: equal t keeps the earlier triangle
        exp_q.push_back(hit_rec(8'd6, 32'h40A00000, 16'd1));
        drive(1, 0, 8'd6, 1, 32'h40A00000, 16'd1);
        drive(0, 1, 8'd6, 1, 32'h40A00000, 16'd2);

        // Ray 7: 6.0 tri 4 then 1.0 tri 8
`ifdef INT_COLLECT_ANYHIT_EN
        exp_q.push_back(hit_rec(8'd7, 32'h40C00000, 16'd4));
`else
        exp_q.push_back(hit_rec(8'd7, 32'h3F800000, 16'd8));
`endif
        drive(1, 0, 8'd7, 1, 32'h40C00000, 16'd4);
        drive(0, 1, 8'd7, 1, 32'h3F800000, 16'd8);
        drain("drain_basic");
        check("err_clean", err_out, 0);

        // Stray non-first result while idle
        drive(0, 0, 8'd9, 1, 32'h3F800000, 16'd5);
        idle(1);
        check("err_stray", err_out, 1);

        // Second first while a ray is open: only ray 11 is emitted
        do_reset_seq();
`ifdef INT_COLLECT_ANYHIT_EN
        exp_q.push_back(hit_rec(8'd11, 32'h40400000, 16'd12));
`else
        exp_q.push_back(hit_rec(8'd11, 32'h40000000, 16'd13));
`endif
        drive(1, 0, 8'd10, 1, 32'h3F800000, 16'd11);
        drive(1, 0, 8'd11, 1, 32'h40400000, 16'd12);
        check("err_refirst", err_out, 1);
        drive(0, 1, 8'd11, 1, 32'h40000000, 16'd13);
        drain("drain_refirst");

        // Fill with consumer stalled: stall, overflow drop, stable head
        do_reset_seq();
        res_ready_in = 1'b0;
        for (int k = 0; k < 4; k++)
            exp_q.push_back(hit_rec(8'(20 + k), 32'h3F800000, 16'(100 + k)));
        drive(1, 1, 8'd20, 1, 32'h3F800000, 16'd100);
        check("stall_after_1", int_stall_out, 0);
        drive(1, 1, 8'd21, 1, 32'h3F800000, 16'd101);
        drive(1, 1, 8'd22, 1, 32'h3F800000, 16'd102);
        check("stall_set", int_stall_out, 1);
        drive(1, 1, 8'd23, 1, 32'h3F800000, 16'd103);
        check("err_before_drop", err_out, 0);
        drive(1, 1, 8'd24, 1, 32'h3F800000, 16'd104);
        check("err_overflow", err_out, 1);
        idle(2);
        check("head_ray_stable", res_rayID_out, 20);
        check("head_tri_stable", res_triID_out, 100);
        res_ready_in = 1'b1;
        drain("drain_full");
        idle(2);
        check("valid_empty", res_valid_out, 0);
        check("stall_clear", int_stall_out, 0);

        // Reset with two records queued and a ray open
        res_ready_in = 1'b0;
        drive(1, 1, 8'd40, 1, 32'h3F800000, 16'd40);
        drive(1, 1, 8'd41, 1, 32'h3F800000, 16'd41);
        drive(1, 0, 8'd42, 1, 32'h3F800000, 16'd42);
        check("stall_before_rst", int_stall_out, 1);
        rst = 1'b1;
        idle(1);
        check("rst_valid", res_valid_out, 0);
        check("rst_stall", int_stall_out, 0);
        check("rst_err", err_out, 0);
        check("rst_t", res_t_out, 0);
        rst = 1'b0;
        res_ready_in = 1'b1;
        exp_q.push_back(hit_rec(8'd30, 32'h40200000, 16'd9));
        drive(1, 0, 8'd30, 0, 32'h3F800000, 16'd2);
        drive(0, 1, 8'd30, 1, 32'h40200000, 16'd9);
        drain("drain_after_rst");
        idle(3);
        check("final_err", err_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    task automatic do_reset_seq();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

endmodule
